// File: rtl/pairing_job_ctrl_pkg.sv
// pairing_job_ctrl_pkg: shared params, operand word type and job FSM states
package pairing_job_ctrl_pkg;
   localparam int BRAM_DEPTH = 8;
   typedef logic [31:0] redundant_poly_L3;
   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, RUN, UNLOAD, DONE} job_state_t;
   function automatic logic [23:0] sat_inc(input logic [23:0] v);
      return &v ? v : v + 24'd1;
   endfunction
endpackage

// File: rtl/pairing_job_ctrl_if.sv
// pairing_job_ctrl_if: command, operand/result streams and core port of the job controller
interface pairing_job_ctrl_if import pairing_job_ctrl_pkg::*; #(
   parameter int AW = BRAM_DEPTH,
   parameter int W = $bits(redundant_poly_L3)
);
   logic cmd_valid, cmd_ready;
   logic [3:0] cmd_func;
   logic [AW-1:0] cmd_in_base, cmd_out_base;
   logic [AW:0] cmd_in_len, cmd_out_len;
   logic in_valid, in_ready;
   logic [W-1:0] in_data;
   logic out_valid, out_ready;
   logic [W-1:0] out_data;
   logic core_run, core_busy;
   logic [3:0] core_n_func;
   logic core_extin_en;
   logic [AW-1:0] core_extin_addr, core_extout_addr;
   logic [W-1:0] core_extin_data, core_extout_data;
   modport slave (
      input cmd_valid, cmd_func, cmd_in_base, cmd_out_base, cmd_in_len, cmd_out_len,
      input in_valid, in_data, out_ready, core_busy, core_extout_data,
      output cmd_ready, in_ready, out_valid, out_data, core_run, core_n_func,
      output core_extin_en, core_extin_addr, core_extin_data, core_extout_addr
   );
   modport master (
      output cmd_valid, cmd_func, cmd_in_base, cmd_out_base, cmd_in_len, cmd_out_len,
      output in_valid, in_data, out_ready, core_busy, core_extout_data,
      input cmd_ready, in_ready, out_valid, out_data, core_run, core_n_func,
      input core_extin_en, core_extin_addr, core_extin_data, core_extout_addr
   );
endinterface

// File: rtl/pairing_job_ctrl_rd_skid_fifo.sv
// rd_skid_fifo: small circular buffer holding core readback words, with occupancy output
module rd_skid_fifo #(
   parameter int DEPTH = 3,
   parameter int W = 32,
   localparam int CW = $clog2(DEPTH + 1)
)(
   input  logic clk,
   input  logic rstn,
   input  logic push,
   input  logic [W-1:0] din,
   input  logic pop,
   output logic [W-1:0] dout,
   output logic valid,
   output logic [CW-1:0] count
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [W-1:0] mem [DEPTH];
   logic [PW-1:0] rd, wr;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   always_ff @(posedge clk)
      if (push) mem[wr] <= din;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         rd <= '0;
         wr <= '0;
         count <= '0;
      end else begin
         if (push) wr <= nxt(wr);
         if (pop) rd <= nxt(rd);
         count <= count + CW'(push) - CW'(pop);
      end
   assign valid = count != '0;
   assign dout = valid ? mem[rd] : '0;
endmodule

// File: rtl/pairing_job_ctrl.sv
// pairing_job_ctrl: loads operands into core memory, runs the core, streams results back
module pairing_job_ctrl import pairing_job_ctrl_pkg::*; #(
   parameter int AW = BRAM_DEPTH,
   parameter int W = $bits(redundant_poly_L3),
   parameter int RD_LAT = 2,
   parameter int BUSY_TMO = 8
)(
   input  logic clk,
   input  logic rstn,
   pairing_job_ctrl_if.slave bus,
   output logic done,
   output logic err_tmo,
   output logic [23:0] cycles
);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(RD_LAT + 2);
   localparam int TW = $clog2(BUSY_TMO + 1);
   job_state_t state;
   logic [3:0] func;
   logic [AW-1:0] in_base, out_base;
   logic [LW-1:0] in_len, out_len, k, j, xfer;
   logic [TW-1:0] tmo;
   logic [RD_LAT-1:0] pipe;
   logic [CW-1:0] occ;
   logic issue, pop;
   assign bus.cmd_ready = state == IDLE;
   assign bus.in_ready = state == LOAD;
   assign bus.core_run = state == START;
   assign bus.core_n_func = func;
   assign bus.core_extin_en = bus.in_ready && bus.in_valid;
   assign bus.core_extin_addr = in_base + k[AW-1:0];
   assign bus.core_extin_data = bus.core_extin_en ? bus.in_data : '0;
   assign bus.core_extout_addr = out_base + j[AW-1:0];
   // in-flight reads plus buffered words never exceed the buffer depth
   assign issue = state == UNLOAD && j != out_len && ($countones(pipe) + int'(occ) < RD_LAT + 1);
   assign pop = bus.out_valid && bus.out_ready;
   rd_skid_fifo #(.DEPTH(RD_LAT + 1), .W(W)) u_fifo (
      .clk(clk), .rstn(rstn), .push(pipe[RD_LAT-1]), .din(bus.core_extout_data),
      .pop(pop), .dout(bus.out_data), .valid(bus.out_valid), .count(occ)
   );
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state <= IDLE;
         func <= '0;
         in_base <= '0;
         out_base <= '0;
         in_len <= '0;
         out_len <= '0;
         k <= '0;
         j <= '0;
         xfer <= '0;
         tmo <= '0;
         pipe <= '0;
         done <= 1'b0;
         err_tmo <= 1'b0;
         cycles <= '0;
      end else begin
         done <= 1'b0;
         pipe <= (pipe << 1) | RD_LAT'(issue);
         case (state)
            IDLE: if (bus.cmd_valid) begin
               func <= bus.cmd_func;
               in_base <= bus.cmd_in_base;
               out_base <= bus.cmd_out_base;
               in_len <= bus.cmd_in_len;
               out_len <= bus.cmd_out_len;
               k <= '0;
               j <= '0;
               xfer <= '0;
               err_tmo <= 1'b0;
               state <= bus.cmd_in_len == '0 ? START : LOAD;
            end
            LOAD: if (bus.in_valid) begin
               k <= k + 1'b1;
               if (k + 1'b1 == in_len) state <= START;
            end
            START: begin
               cycles <= '0;
               err_tmo <= 1'b0;
               tmo <= TW'(1);
               state <= WAIT_BUSY;
            end
            // tmo counts cycles since core_run, so the timeout lands BUSY_TMO cycles after it
            WAIT_BUSY: if (bus.core_busy) begin
               cycles <= 24'd1;
               state <= RUN;
            end else if (tmo == TW'(BUSY_TMO - 1)) begin
               err_tmo <= 1'b1;
               done <= 1'b1;
               state <= IDLE;
            end else tmo <= tmo + 1'b1;
            RUN: if (!bus.core_busy) begin
               state <= out_len == '0 ? DONE : UNLOAD;
               done <= out_len == '0;
            end else cycles <= sat_inc(cycles);
            UNLOAD: begin
               if (issue) j <= j + 1'b1;
               if (pop) xfer <= xfer + 1'b1;
               if (xfer + LW'(pop) == out_len) begin
                  state <= DONE;
                  done <= 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_pairing_job_ctrl.sv
// tb_pairing_job_ctrl: directed jobs against a core/memory model, scoreboard-checked outputs
module tb_pairing_job_ctrl;
   import pairing_job_ctrl_pkg::*;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic done, err_tmo;
   logic [23:0] cycles;
   always #5 clk = ~clk;
   pairing_job_ctrl_if #(.AW(8), .W(32)) bus();
   pairing_job_ctrl #(.AW(8), .W(32), .RD_LAT(2), .BUSY_TMO(8)) dut (
      .clk(clk), .rstn(rstn), .bus(bus), .done(done), .err_tmo(err_tmo), .cycles(cycles)
   );
   int n_vec = 0, n_err = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask
   task automatic flag(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: unexpected DUT activity or expired wait", name);
   endtask
   // core model: memory with RD_LAT=2 readback and a programmable busy window
   logic [31:0] mem [256];
   bit wrote [256];
   logic [7:0] r1;
   int bcnt = 0, busy_dly = 2, busy_len = 0, rdy_mode = 1;
   always @(posedge clk) begin
      if (bus.core_extin_en) begin
         mem[bus.core_extin_addr] <= bus.core_extin_data;
         wrote[bus.core_extin_addr] <= 1'b1;
      end
      r1 <= bus.core_extout_addr;
      bus.core_extout_data <= wrote[r1] ? mem[r1] : (32'hC0DE_0000 | 32'(r1));
      bcnt <= bus.core_run ? 1 : (bcnt > 0 && bcnt < 100000) ? bcnt + 1 : bcnt;
   end
   assign bus.core_busy = bcnt >= busy_dly && bcnt < busy_dly + busy_len;
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 bus.out_ready = rdy_mode == 2 ? ~bus.out_ready : rdy_mode == 1;
      end
   end
   typedef struct packed {logic [7:0] a; logic [31:0] d;} wr_t;
   wr_t wr_q[$];
   wr_t w;
   logic [31:0] out_q[$];
   logic [3:0] run_q[$];
   logic [24:0] done_q[$];
   int ext_first, ext_last, ext_n, run_at, run_n, done_at, done_n, fall_at, first_out_at;
   logic prev_busy = 1'b0;
   always @(negedge clk) if (rstn) begin
      if (bus.core_extin_en) begin
         if (wr_q.size() == 0) flag("extin_extra");
         else begin
            w = wr_q.pop_front();
            check("extin_addr", bus.core_extin_addr, w.a);
            check("extin_data", bus.core_extin_data, w.d);
         end
         if (ext_n == 0) ext_first = cyc;
         ext_last = cyc;
         ext_n++;
      end
      if (bus.core_run) begin
         if (run_q.size() == 0) flag("core_run_extra");
         else check("core_n_func", bus.core_n_func, run_q.pop_front());
         run_at = cyc;
         run_n++;
      end
      if (bus.out_valid && bus.out_ready) begin
         if (out_q.size() == 0) flag("out_extra");
         else check("out_data", bus.out_data, out_q.pop_front());
      end
      if (bus.out_valid && first_out_at < 0) first_out_at = cyc;
      if (prev_busy && !bus.core_busy) fall_at = cyc;
      prev_busy = bus.core_busy;
      if (done) begin
         if (done_q.size() == 0) flag("done_extra");
         else check("done_err_cycles", {err_tmo, cycles}, done_q.pop_front());
         done_at = cyc;
         done_n++;
      end
   end
   task automatic clr_marks();
      ext_n = 0; run_n = 0; done_n = 0;
      fall_at = -1; first_out_at = -1; run_at = -1; done_at = -1;
   endtask
   task automatic issue(input logic [3:0] f, input logic [7:0] ib, input int il,
                        input logic [7:0] ob, input int ol, input logic [31:0] dbase);
      int n;
      for (int i = 0; i < il; i++) wr_q.push_back({8'(ib + 8'(i)), dbase + 32'(i)});
      run_q.push_back(f);
      @(posedge clk);
      #1;
      bus.cmd_func = f; bus.cmd_in_base = ib; bus.cmd_out_base = ob;
      bus.cmd_in_len = 9'(il); bus.cmd_out_len = 9'(ol); bus.cmd_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
      if (!bus.cmd_ready) flag("cmd_ready_wait");
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      for (int i = 0; i < il; i++) begin
         bus.in_data = dbase + 32'(i);
         bus.in_valid = 1'b1;
         n = 0;
         @(negedge clk);
         while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
         if (!bus.in_ready) flag("in_ready_wait");
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask
   task automatic wait_done(input int budget);
      int start, n;
      start = done_n;
      n = 0;
      while (done_n == start && n < budget) begin @(negedge clk); n++; end
      if (done_n == start) flag("done_wait");
      repeat (2) @(negedge clk);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      bus.cmd_valid = 0; bus.cmd_func = 0; bus.cmd_in_base = 0; bus.cmd_out_base = 0;
      bus.cmd_in_len = 0; bus.cmd_out_len = 0; bus.in_valid = 0; bus.in_data = 0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_core_run", bus.core_run, 0);
      check("rst_extin_en", bus.core_extin_en, 0);
      check("rst_done", done, 0);
      check("rst_err_tmo", err_tmo, 0);
      check("rst_cycles", cycles, 0);
      // load 4 beats, 100-cycle core run, unload 6 words under toggling out_ready
      clr_marks(); busy_dly = 2; busy_len = 100; rdy_mode = 2;
      for (int i = 0; i < 6; i++) out_q.push_back(32'hC0DE_0020 + 32'(i));
      done_q.push_back({1'b0, 24'd100});
      issue(4'd3, 8'h10, 4, 8'h20, 6, 32'hAA00_0000);
      wait_done(400);
      check("load_beats", ext_n, 4);
      check("load_consecutive", ext_last - ext_first, 3);
      check("run_after_load", run_at - ext_last, 1);
      check("run_pulses", run_n, 1);
      check("busy_span", fall_at - run_at, 102);
      check("unload_latency", first_out_at - fall_at, 4);
      check("job1_out_drained", out_q.size(), 0);
      check("job1_done_pulses", done_n, 1);
      // core never goes busy
      clr_marks(); busy_len = 0; rdy_mode = 1;
      done_q.push_back({1'b1, 24'd0});
      issue(4'd5, 8'h00, 0, 8'h50, 2, 32'h0);
      wait_done(100);
      check("tmo_done_delay", done_at - run_at, 8);
      check("tmo_idle", bus.cmd_ready, 1);
      check("tmo_err_sticky", err_tmo, 1);
      check("tmo_done_pulses", done_n, 1);
      // empty job
      clr_marks(); busy_dly = 2; busy_len = 3;
      done_q.push_back({1'b0, 24'd3});
      issue(4'd7, 8'h00, 0, 8'h00, 0, 32'h0);
      wait_done(100);
      check("empty_done_delay", done_at - fall_at, 1);
      check("empty_err_clear", err_tmo, 0);
      check("empty_no_extin", ext_n, 0);
      check("empty_run_pulses", run_n, 1);
      // address wrap on both load and unload
      clr_marks(); busy_dly = 3; busy_len = 5;
      out_q.push_back(32'h5500_0001); out_q.push_back(32'h5500_0002); out_q.push_back(32'h5500_0003);
      done_q.push_back({1'b0, 24'd5});
      issue(4'd1, 8'hFE, 4, 8'hFF, 3, 32'h5500_0000);
      wait_done(200);
      check("wrap_out_drained", out_q.size(), 0);
      check("wrap_load_beats", ext_n, 4);
      // reset while unload holds buffered words
      clr_marks(); busy_dly = 2; busy_len = 2; rdy_mode = 0;
      issue(4'd2, 8'h00, 0, 8'h40, 5, 32'h0);
      n = 0;
      while (!bus.out_valid && n < 200) begin @(negedge clk); n++; end
      if (!bus.out_valid) flag("unload_valid_wait");
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_out_data", bus.out_data, 0);
      check("midrst_in_ready", bus.in_ready, 0);
      check("midrst_cycles", cycles, 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      rdy_mode = 1;
      @(negedge clk);
      check("postrst_cmd_ready", bus.cmd_ready, 1);
      check("postrst_out_valid", bus.out_valid, 0);
      // clean job after the reset
      clr_marks(); busy_dly = 2; busy_len = 4;
      out_q.push_back(32'h7700_0000); out_q.push_back(32'h7700_0001);
      done_q.push_back({1'b0, 24'd4});
      issue(4'd4, 8'h30, 2, 8'h30, 2, 32'h7700_0000);
      wait_done(200);
      check("final_out_drained", out_q.size(), 0);
      check("final_done_pulses", done_n, 1);
      check("queues_empty", wr_q.size() + run_q.size() + done_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
